// File: rtl/ps2_num_scheduler.sv
// ps2_num_scheduler: detects completed keypad entries, converts BCD digits to binary
// over a fixed multi-cycle sequence and queues operands in a first-word fall-through FIFO.
module ps2_num_scheduler #(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [3:0]    iNum1,
    input  logic [3:0]    iNum2,
    input  logic [3:0]    iNum3,
    input  logic          iNumRdy,
    input  logic          iReady,
    input  logic          iClrErr,
    output logic [9:0]    oData,
    output logic          oValid,
    output logic [CW-1:0] oCount,
    output logic          oBusy,
    output logic [1:0]    oErr
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, ACC1, ACC2, ACC3, PUSH} state_t;
    state_t        state_q, state_d;
    logic          rdy_q;
    logic [3:0]    d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
    logic [9:0]    acc_q, acc_d;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_q, err_d;
    logic          rise, ok, idle, pop, room, push;
    logic [9:0]    acc_x10;
    assign rise    = iNumRdy & ~rdy_q;
    assign ok      = (iNum1 <= 4'd9) & (iNum2 <= 4'd9) & (iNum3 <= 4'd9);
    assign idle    = state_q == IDLE;
    assign pop     = oValid & iReady;
    assign room    = (cnt_q < CW'(DEPTH)) | pop;
    assign push    = (state_q == PUSH) & room;
    assign acc_x10 = (acc_q << 3) + (acc_q << 1);
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
    assign err_d   = (iClrErr ? 2'b00 : err_q) |
                     {(rise & ~idle) | ((state_q == PUSH) & ~room), rise & idle & ~ok};
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        case (state_q)
            IDLE: if (rise && ok) begin
                state_d = ACC1;
                d1_d    = iNum1;
                d2_d    = iNum2;
                d3_d    = iNum3;
            end
            ACC1: begin
                acc_d   = {6'd0, d1_q};
                state_d = ACC2;
            end
            ACC2: begin
                acc_d   = acc_x10 + {6'd0, d2_q};
                state_d = ACC3;
            end
            ACC3: begin
                acc_d   = acc_x10 + {6'd0, d3_q};
                state_d = PUSH;
            end
            default: state_d = IDLE;
        endcase
    end
    // rdy_q resets high so a level already asserted at reset release is not an edge
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            acc_q   <= '0;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= iNumRdy;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            acc_q   <= acc_d;
            if (push) mem_q[wr_q] <= acc_q;
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    assign oData  = mem_q[rd_q];
    assign oValid = cnt_q != '0;
    assign oCount = cnt_q;
    assign oBusy  = ~idle;
    assign oErr   = err_q;
endmodule

// File: tb/tb_ps2_num_scheduler.sv
// tb_ps2_num_scheduler: vector table plus scoreboard bench for the keypad operand scheduler.
module tb_ps2_num_scheduler;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    logic          CLK = 1'b0;
    logic          reset;
    logic [3:0]    iNum1, iNum2, iNum3;
    logic          iNumRdy, iReady, iClrErr;
    logic [9:0]    oData;
    logic          oValid;
    logic [CW-1:0] oCount;
    logic          oBusy;
    logic [1:0]    oErr;
    int            total = 0;
    int            bad = 0;
    int            sb[$];
    typedef struct {
        logic [3:0] a, b, c;
        bit         push;
        int         cnt;
        logic [1:0] err;
    } vec_t;
    vec_t vecs[6];

    ps2_num_scheduler #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .reset(reset), .iNum1(iNum1), .iNum2(iNum2), .iNum3(iNum3),
        .iNumRdy(iNumRdy), .iReady(iReady), .iClrErr(iClrErr), .oData(oData),
        .oValid(oValid), .oCount(oCount), .oBusy(oBusy), .oErr(oErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Pops occur at the next posedge, so compare against the scoreboard head here
    always @(negedge CLK) begin
        if (!reset && oValid && iReady) begin
            chk("pop_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) chk("pop_data", oData, sb.pop_front());
        end
    end

    task automatic enter(input logic [3:0] a, b, c, input bit exp_push, input bit rdy_push);
        bit ok = (a <= 9) && (b <= 9) && (c <= 9);
        int val = int'(a) * 100 + int'(b) * 10 + int'(c);
        @(posedge CLK); #1;
        iNum1 = a; iNum2 = b; iNum3 = c; iNumRdy = 1'b1;
        @(posedge CLK); #1;
        iNumRdy = 1'b0;
        chk("busy_k", oBusy, ok);
        repeat (3) @(posedge CLK);
        #1;
        chk("busy_k3", oBusy, ok);
        chk("cnt_pre", oCount, sb.size());
        if (rdy_push) iReady = 1'b1;
        @(posedge CLK); #1;
        if (rdy_push) iReady = 1'b0;
        chk("busy_k4", oBusy, 0);
        if (exp_push) sb.push_back(val);
        chk("cnt_post", oCount, sb.size());
    endtask

    task automatic drain(input int n);
        @(posedge CLK); #1;
        iReady = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        iReady = 1'b0;
        chk("drain_valid", oValid, 0);
        chk("drain_cnt", oCount, 0);
        chk("drain_sb", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd1, 4'd2, 4'd3, 1'b1, 1, 2'b00};
        vecs[1] = '{4'd9, 4'd9, 4'd9, 1'b1, 2, 2'b00};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 1'b1, 3, 2'b00};
        vecs[3] = '{4'd7, 4'd0, 4'd5, 1'b1, 4, 2'b00};
        vecs[4] = '{4'd4, 4'd5, 4'd6, 1'b0, 4, 2'b10};
        vecs[5] = '{4'd0, 4'hA, 4'd0, 1'b0, 4, 2'b11};
        reset = 1'b1; iNum1 = 0; iNum2 = 0; iNum3 = 0;
        iNumRdy = 0; iReady = 0; iClrErr = 0;
        #12;
        chk("rst_data", oData, 0);
        chk("rst_valid", oValid, 0);
        chk("rst_cnt", oCount, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_err", oErr, 0);
        @(posedge CLK); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enter(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].push, 1'b0);
            chk("vec_cnt", oCount, vecs[i].cnt);
            chk("vec_err", oErr, vecs[i].err);
            chk("vec_valid", oValid, vecs[i].cnt != 0);
            if (sb.size() != 0) chk("vec_head", oData, sb[0]);
        end
        @(posedge CLK); #1;
        iClrErr = 1'b1;
        @(posedge CLK); #1;
        iClrErr = 1'b0;
        chk("clr_err", oErr, 0);
        drain(DEPTH);
        for (int i = 0; i < DEPTH; i++)
            enter(4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9)), 1'b1, 1'b0);
        enter(4'd3, 4'd1, 4'd4, 1'b1, 1'b1);
        chk("sim_cnt", oCount, DEPTH);
        chk("sim_err", oErr, 0);
        drain(DEPTH + 1);
        enter(4'd5, 4'hA, 4'd1, 1'b0, 1'b0);
        chk("inv_err", oErr, 2'b01);
        chk("inv_cnt", oCount, 0);
        @(posedge CLK); #1;
        iClrErr = 1'b1;
        @(posedge CLK); #1;
        iClrErr = 1'b0;
        chk("inv_clr", oErr, 0);
        @(posedge CLK); #1;
        iNum2 = 4'hA; iNumRdy = 1'b1; iClrErr = 1'b1;
        @(posedge CLK); #1;
        iNumRdy = 1'b0; iClrErr = 1'b0;
        chk("set_over_clr", oErr, 2'b01);
        chk("set_over_clr_busy", oBusy, 0);
        @(posedge CLK); #1;
        iClrErr = 1'b1;
        @(posedge CLK); #1;
        iClrErr = 1'b0;
        enter(4'd2, 4'd5, 4'd0, 1'b1, 1'b0);
        enter(4'd0, 4'd0, 4'd7, 1'b1, 1'b0);
        @(posedge CLK); #1;
        iNum1 = 6; iNum2 = 6; iNum3 = 6; iNumRdy = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("acc2_busy", oBusy, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_data", oData, 0);
        chk("ar_valid", oValid, 0);
        chk("ar_cnt", oCount, 0);
        chk("ar_busy", oBusy, 0);
        chk("ar_err", oErr, 0);
        sb.delete();
        @(posedge CLK); #1;
        reset = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("held_rdy_cnt", oCount, 0);
        chk("held_rdy_busy", oBusy, 0);
        iNumRdy = 1'b0;
        enter(4'd8, 4'd4, 4'd2, 1'b1, 1'b0);
        chk("post_rst_head", oData, 842);
        drain(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
